// File: rtl/turret_pkg.sv
// Shared types and constants for the I2S microphone receive path.
package turret_pkg;

  localparam int unsigned I2S_SAMPLE_W   = 18;
  localparam int unsigned I2S_SLOT_W     = 32;
  localparam int unsigned I2S_FRAME_BITS = 64;

  typedef logic signed [I2S_SAMPLE_W-1:0] mic_sample_t;

  typedef enum logic {IDLE, RUN} i2s_state_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK divider: toggles bclk every CLK_DIV cycles while run_i is high, parks low otherwise.
module i2s_bclk_gen #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic bclk_o,
  output logic bclk_fall_stb_o,
  output logic sample_stb_o
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DivW-1:0] div_q, div_d;
  logic            bclk_q, bclk_d;
  logic            div_end;

  assign div_end = (div_q == DivW'(CLK_DIV - 1));

  always_comb begin
    div_d  = div_q;
    bclk_d = bclk_q;
    if (!run_i) begin
      div_d  = '0;
      bclk_d = 1'b0;
    end else if (div_end) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  // Last high cycle doubles as the sampling point and the falling-edge decision.
  assign sample_stb_o    = run_i & bclk_q & div_end;
  assign bclk_fall_stb_o = run_i & bclk_q & div_end;
  assign bclk_o          = bclk_q;

endmodule

// File: rtl/i2s_mic_rx.sv
// Master-mode I2S receiver for one 18-bit MEMS mic; one sample per 64-bit frame on data/data_rdy.
module i2s_mic_rx
  import turret_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16,
  parameter int unsigned CHANNEL = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    mic_sd,
  output logic                    mic_bclk,
  output logic                    mic_ws,
  output logic [I2S_SAMPLE_W-1:0] data,
  output logic                    data_rdy
);

  localparam int unsigned CntW    = $clog2(I2S_FRAME_BITS);
  localparam int unsigned SlotBit = $clog2(I2S_SLOT_W);
  localparam logic        ChanSel = 1'(CHANNEL);

  i2s_state_t              state_q;
  logic [CntW-1:0]         bit_cnt_q, bit_cnt_nxt;
  logic                    ws_q;
  logic                    sd_meta_q, sd_s_q;
  logic [I2S_SAMPLE_W-1:0] shreg_q, shreg_nxt;
  mic_sample_t             data_q;
  logic                    rdy_q;
  logic [SlotBit-1:0]      slot_idx;
  logic                    capture;
  logic                    bclk_fall_stb, sample_stb;

  i2s_bclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_bclk_gen (
    .clk_i          (clock),
    .rst_ni         (reset_n),
    .run_i          (state_q == RUN),
    .bclk_o         (mic_bclk),
    .bclk_fall_stb_o(bclk_fall_stb),
    .sample_stb_o   (sample_stb)
  );

  assign bit_cnt_nxt = bit_cnt_q + 1'b1;
  assign slot_idx    = bit_cnt_q[SlotBit-1:0];
  // Slot index 0 is the I2S one-bit delay; bits past the sample width are padding.
  assign capture     = (bit_cnt_q[SlotBit] == ChanSel) && (slot_idx >= SlotBit'(1)) &&
                       (slot_idx <= SlotBit'(I2S_SAMPLE_W));
  assign shreg_nxt   = {shreg_q[I2S_SAMPLE_W-2:0], sd_s_q};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      ws_q      <= 1'b0;
      sd_meta_q <= 1'b0;
      sd_s_q    <= 1'b0;
      shreg_q   <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
    end else begin
      sd_meta_q <= mic_sd;
      sd_s_q    <= sd_meta_q;
      rdy_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          bit_cnt_q <= '0;
          ws_q      <= 1'b0;
          if (enable) state_q <= RUN;
        end
        RUN: begin
          if (sample_stb && capture) begin
            shreg_q <= shreg_nxt;
            if (slot_idx == SlotBit'(I2S_SAMPLE_W)) begin
              data_q <= shreg_nxt;
              rdy_q  <= 1'b1;
            end
          end
          if (bclk_fall_stb) begin
            bit_cnt_q <= bit_cnt_nxt;
            ws_q      <= bit_cnt_nxt[SlotBit];
            // Stop only on a frame boundary so the far slot always finishes.
            if ((bit_cnt_q == {CntW{1'b1}}) && !enable) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mic_ws   = ws_q;
  assign data     = data_q;
  assign data_rdy = rdy_q;

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Bench: a behavioural I2S mic feeds a left and a right receiver; a scoreboard checks each strobe.
module tb_i2s_mic_rx;

  localparam int unsigned CLK_DIV  = 16;
  localparam int          FRAME_CYC = 128 * CLK_DIV;
  localparam int          SLOT_CYC  = 64 * CLK_DIV;

  typedef struct {
    logic [17:0] l;
    logic [17:0] r;
    logic        g;
  } frame_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic        mic_sd = 1'b0;
  logic        bclk0, ws0, rdy0, bclk1, ws1, rdy1;
  logic [17:0] data0, data1;

  always #5 clock = ~clock;

  i2s_mic_rx #(.CLK_DIV(CLK_DIV), .CHANNEL(0)) dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .mic_sd  (mic_sd),
    .mic_bclk(bclk0),
    .mic_ws  (ws0),
    .data    (data0),
    .data_rdy(rdy0)
  );

  i2s_mic_rx #(.CLK_DIV(CLK_DIV), .CHANNEL(1)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .mic_sd  (mic_sd),
    .mic_bclk(bclk1),
    .mic_ws  (ws1),
    .data    (data1),
    .data_rdy(rdy1)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          falls = 0;
  int          s0 = 0;
  int          s1 = 0;
  int          t0_q[$];
  int          t1_q[$];
  logic [17:0] exp0[$];
  logic [17:0] exp1[$];
  logic [17:0] last0 = '0;
  logic [17:0] last1 = '0;
  logic [17:0] e0, e1;
  frame_t      frame_q[$];
  frame_t      cur;
  int          mpos = 0;
  logic        mslot = 1'b0;
  logic        prev_ws = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic push_frame(input logic [17:0] l, input logic [17:0] r, input logic g);
    frame_t f;
    f.l = l;
    f.r = r;
    f.g = g;
    frame_q.push_back(f);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_bclk0"}, 32'(bclk0), 0);
    chk({nm, "_ws0"}, 32'(ws0), 0);
    chk({nm, "_data0"}, 32'(data0), 0);
    chk({nm, "_rdy0"}, 32'(rdy0), 0);
    chk({nm, "_bclk1"}, 32'(bclk1), 0);
    chk({nm, "_ws1"}, 32'(ws1), 0);
    chk({nm, "_data1"}, 32'(data1), 0);
    chk({nm, "_rdy1"}, 32'(rdy1), 0);
  endtask

  task automatic wait_strobes0(input int target, input int budget, input string nm);
    int k = 0;
    while (s0 < target && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk(nm, 32'(s0), 32'(target));
  endtask

  // Waits until the mic is driving left-slot bit p (the receiver's bit count equals p).
  task automatic wait_left_pos(input int p, input int budget, input string nm);
    int k = 0;
    while (!(mpos == p && mslot == 1'b0) && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk(nm, 32'(k < budget), 1);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge bclk0) if (reset_n === 1'b1) falls <= falls + 1;

  always @(negedge reset_n) begin
    mpos    = 0;
    prev_ws = 1'b0;
  end

  // Mic model: bit position counts falling BCLKs since the last WS change; MSB at position 1.
  initial begin : mic
    forever begin
      @(negedge bclk0);
      #1;
      if (reset_n !== 1'b1) continue;
      if (ws0 !== prev_ws) mpos = 0;
      else mpos++;
      prev_ws = ws0;
      mslot   = ws0;
      if (mpos == 1) begin
        if (!mslot) begin
          if (frame_q.size() > 0) cur = frame_q.pop_front();
          else begin
            cur.l = 18'($urandom);
            cur.r = 18'($urandom);
            cur.g = 1'($urandom);
          end
          exp0.push_back(cur.l);
        end else begin
          exp1.push_back(cur.r);
        end
      end
      #9;
      if (mpos >= 1 && mpos <= 18) mic_sd = mslot ? cur.r[18-mpos] : cur.l[18-mpos];
      else if (mpos == 0 && !mslot && frame_q.size() > 0) mic_sd = frame_q[0].g;
      else mic_sd = cur.g;
    end
  end

  // Scoreboard monitor.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (rdy0 === 1'b1) begin
        if (exp0.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL strobe0_unexpected: data %0h, no sample expected", data0);
        end else begin
          e0 = exp0.pop_front();
          chk("data0", 32'(data0), 32'(e0));
          last0 = e0;
        end
        t0_q.push_back(cyc);
        s0++;
      end else begin
        chk("hold0", 32'(data0), 32'(last0));
      end
      if (rdy1 === 1'b1) begin
        if (exp1.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL strobe1_unexpected: data %0h, no sample expected", data1);
        end else begin
          e1 = exp1.pop_front();
          chk("data1", 32'(data1), 32'(e1));
          last1 = e1;
        end
        t1_q.push_back(cyc);
        s1++;
      end else begin
        chk("hold1", 32'(data1), 32'(last1));
      end
    end
  end

  initial begin : stim
    int f_drop;
    int sb;
    #2 reset_n = 1'b0;
    #1 chk_zero("reset");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    repeat (10000) @(negedge clock);
    chk("idle_bclk_falls", 32'(falls), 0);
    chk("idle_strobes", 32'(s0 + s1), 0);
    chk("idle_bclk", 32'(bclk0), 0);
    chk("idle_ws", 32'(ws0), 0);

    repeat (3) push_frame(18'h2A5A5, 18'h15A5A, 1'($urandom));
    push_frame(18'h00001, 18'h3FFFF, 1'($urandom));
    push_frame(18'h20000, 18'h20000, 1'b1);
    push_frame(18'h1FFFF, 18'h1FFFF, 1'b1);
    repeat (4) push_frame(18'($urandom), 18'($urandom), 1'($urandom));
    enable = 1'b1;
    wait_strobes0(10, 12 * FRAME_CYC, "run1_strobes");

    wait_left_pos(10, 2 * FRAME_CYC, "drop_point");
    enable = 1'b0;
    f_drop = falls;
    repeat (2 * FRAME_CYC) @(negedge clock);
    chk("drop_falls", 32'(falls - f_drop), 54);
    chk("drop_strobes0", 32'(s0), 11);
    chk("drop_strobes1", 32'(s1), 11);
    chk("drop_bclk", 32'(bclk0), 0);
    chk("drop_ws", 32'(ws0), 0);
    chk("drop_exp0_left", 32'(exp0.size()), 0);
    chk("drop_exp1_left", 32'(exp1.size()), 0);
    for (int i = 1; i < 11; i++) chk("period0", 32'(t0_q[i] - t0_q[i-1]), 32'(FRAME_CYC));
    for (int i = 0; i < 11; i++) chk("right_offset", 32'(t1_q[i] - t0_q[i]), 32'(SLOT_CYC));

    repeat (2) push_frame(18'($urandom), 18'($urandom), 1'($urandom));
    enable = 1'b1;
    wait_strobes0(13, 4 * FRAME_CYC, "run2_strobes");

    wait_left_pos(9, 2 * FRAME_CYC, "reset_point");
    sb = s0;
    #2 reset_n = 1'b0;
    enable = 1'b0;
    exp0.delete();
    exp1.delete();
    last0 = '0;
    last1 = '0;
    #1 chk_zero("midreset");
    repeat (20) @(negedge clock);
    chk("midreset_no_strobe", 32'(s0), 32'(sb));
    reset_n = 1'b1;
    repeat (2) push_frame(18'($urandom), 18'($urandom), 1'($urandom));
    enable = 1'b1;
    wait_strobes0(sb + 2, 4 * FRAME_CYC, "run3_strobes");
    enable = 1'b0;
    repeat (2 * FRAME_CYC) @(negedge clock);
    chk("end_exp0_left", 32'(exp0.size()), 0);
    chk("end_exp1_left", 32'(exp1.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
